// File: rtl/serial_sub_16bit_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_16bit_pkg
//   Shared definitions for the chunk-serial subtractor: FSM state encodings
//   and the helper that derives the number of chunks per operation.
// ---------------------------------------------------------------------------
package serial_sub_16bit_pkg;

   // FSM state encodings (kept as plain constants for legacy tools)
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Cycles spent in RUN for one operation
   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/serial_sub_16bit_sub_chunk.sv
// ---------------------------------------------------------------------------
// sub_chunk
//   Combinational CHUNK-bit subtract slice: {bout_o, diff_o} = a_i - b_i - bin_i.
//   Ports:
//     a_i    [CHUNK-1:0]  minuend slice
//     b_i    [CHUNK-1:0]  subtrahend slice
//     bin_i               borrow into this slice
//     diff_o [CHUNK-1:0]  difference slice
//     bout_o              borrow out of this slice
// ---------------------------------------------------------------------------
module sub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             bin_i,
   output logic [CHUNK-1:0] diff_o,
   output logic             bout_o
);

   logic [CHUNK:0] res;

   // One extra bit catches the wrap: it is set exactly when the slice borrows
   assign res    = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
   assign diff_o = res[CHUNK-1:0];
   assign bout_o = res[CHUNK];

endmodule

// File: rtl/serial_sub_16bit.sv
// ---------------------------------------------------------------------------
// serial_sub_16bit
//   Multi-cycle unsigned subtractor diff = a - b - bin, CHUNK bits per clock,
//   least-significant chunk first; the borrow is carried between cycles in a
//   register. One op takes NCHUNK RUN cycles plus one DONE cycle.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     start             request, accepted only while ready=1
//     a, b, bin         operands, sampled on the accepting edge
//     ready             1 while idle
//     done              one-cycle pulse, diff/bout valid
//     diff, bout        result and borrow-out, held until the next result
//     ovf               signed overflow (only with SERIAL_SUB_OVF_EN defined)
//   Configuration macro: SERIAL_SUB_OVF_EN adds the ovf output and logic.
// ---------------------------------------------------------------------------
module serial_sub_16bit
   import serial_sub_16bit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             brw_q, brw_d;
   logic             bout_q, bout_d;
   logic [IDXW-1:0]  idx_q, idx_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [31:0]      base;
   logic [CHUNK-1:0] a_sl, b_sl, d_sl;
   logic             bw;
   logic [WIDTH-1:0] work_nxt;

   // Chunk select: the single slice subtractor is time-shared across idx
   assign base = 32'(idx_q) * 32'(CHUNK);
   assign a_sl = a_q[base +: CHUNK];
   assign b_sl = b_q[base +: CHUNK];

   sub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (a_sl),
      .b_i    (b_sl),
      .bin_i  (brw_q),
      .diff_o (d_sl),
      .bout_o (bw)
   );

   // Working register with this cycle's slice merged in; on the last chunk
   // this is the complete result and goes straight to diff.
   always_comb begin
      work_nxt = work_q;
      work_nxt[base +: CHUNK] = d_sl;
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      diff_d  = diff_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      idx_d   = idx_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = a;
               b_d     = b;
               brw_d   = bin;
               idx_d   = '0;
            end
         end
         RUN: begin
            work_d = work_nxt;
            brw_d  = bw;
            idx_d  = idx_q + IDXW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
               diff_d  = work_nxt;
               bout_d  = bw;
`ifdef SERIAL_SUB_OVF_EN
               // Operands of different sign and result sign differs from a
               ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                         (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         diff_q  <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         idx_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         diff_q  <= diff_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         idx_q   <= idx_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign diff  = diff_q;
   assign bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_16bit.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_16bit
//   Self-checking bench for serial_sub_16bit: directed vectors, ignored
//   start during RUN, reset mid-operation, back-to-back with start held,
//   and randomized operands against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_sub_16bit;

   logic        clk = 1'b0;
   logic        rst_n, start, bin;
   logic [15:0] a, b;
   logic        ready, done, bout;
   logic [15:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic        ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_sub_16bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
     ,.ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: 17-bit unsigned subtraction; bit 16 is the borrow-out
   function automatic logic [16:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                           input logic c);
      return {1'b0, x} - {1'b0, y} - {16'd0, c};
   endfunction

   function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y,
                                    input logic c);
      logic [16:0] r;
      r = ref_sub(x, y, c);
      return (x[15] != y[15]) && (r[15] != x[15]);
   endfunction

   // Launch one op from IDLE, scramble inputs after acceptance, wait for done
   // (bounded), then step into the following cycle to observe ready/done.
   task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                        output int cyc, output logic [15:0] d, output logic bo,
                        output logic ov, output logic rdy_after, output logic dn_after);
      cyc = 99;
      @(negedge clk);
      a = x; b = y; bin = c; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (done) begin cyc = i; break; end
      end
      d  = diff;
      bo = bout;
`ifdef SERIAL_SUB_OVF_EN
      ov = ovf;
`else
      ov = 1'b0;
`endif
      @(posedge clk); #1;
      rdy_after = ready;
      dn_after  = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = 16'hFFFF; b = 16'h1234; bin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h expected 0000", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", bout); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [15:0] xs [5] = '{16'h1234, 16'h0000, 16'h0005, 16'h0005, 16'hFFFF};
      logic [15:0] ys [5] = '{16'h0034, 16'h0001, 16'h0005, 16'h0005, 16'h0000};
      logic        cs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] ed [5] = '{16'h1200, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFE};
      logic        eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int cyc; logic [15:0] d; logic bo, ov, rdy, dn;
      for (int k = 0; k < 5; k++) begin
         do_op(xs[k], ys[k], cs[k], cyc, d, bo, ov, rdy, dn);
         checks++; if (cyc != 4) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 4", k, cyc); end
         checks++; if (d !== ed[k]) begin errors++; $display("FAIL dir%0d_diff: got %h expected %h", k, d, ed[k]); end
         checks++; if (bo !== eb[k]) begin errors++; $display("FAIL dir%0d_bout: got %b expected %b", k, bo, eb[k]); end
         checks++; if (rdy !== 1'b1 || dn !== 1'b0) begin errors++; $display("FAIL dir%0d_after: got ready=%b done=%b expected 1/0", k, rdy, dn); end
      end
   endtask

   task automatic test_ignore_start();
      int n_done = 0;
      @(negedge clk);
      a = 16'h00F0; b = 16'h000F; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      @(negedge clk); a = 16'hFFFF; b = 16'h0000; start = 1'b1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ign_busy: got ready=%b expected 0", ready); end
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL ign_pulses: got %0d expected 1", n_done); end
      checks++; if (diff !== 16'h00E1) begin errors++; $display("FAIL ign_diff: got %h expected 00e1", diff); end
      checks++; if (bout !== 1'b0) begin errors++; $display("FAIL ign_bout: got %b expected 0", bout); end
   endtask

   task automatic test_reset_midrun();
      int n_done = 0;
      @(negedge clk);
      a = 16'h4321; b = 16'h1111; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
      checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL rst_mid_diff: got %h expected 0000", diff); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      checks++; if (n_done != 0) begin errors++; $display("FAIL rst_mid_nodone: got %0d pulses expected 0", n_done); end
   endtask

   // start held high: ops follow each other every NCHUNK+2 = 6 cycles
   task automatic test_back_to_back();
      logic [15:0] x, y; logic c; logic [16:0] r;
      int last = -1, t = 0, got;
      @(negedge clk);
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      a = x; b = y; bin = c; start = 1'b1;
      for (int k = 0; k < 5; k++) begin
         got = 0;
         for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1; t++;
            if (done) begin got = 1; break; end
         end
         r = ref_sub(x, y, c);
         checks++; if (got != 1) begin errors++; $display("FAIL b2b%0d_timeout: got no done expected done", k); end
         checks++; if (diff !== r[15:0] || bout !== r[16]) begin errors++; $display("FAIL b2b%0d_result: got %h/%b expected %h/%b", k, diff, bout, r[15:0], r[16]); end
         if (last >= 0) begin
            checks++; if (t - last != 6) begin errors++; $display("FAIL b2b%0d_gap: got %0d expected 6", k, t - last); end
         end
         last = t;
         x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
         a = x; b = y; bin = c;
      end
      @(negedge clk); start = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   task automatic test_random();
      logic [15:0] x, y, d; logic c, bo, ov, rdy, dn; logic [16:0] r; int cyc;
      for (int k = 0; k < 20; k++) begin
         x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
         if (k == 0) begin x = 16'h0000; y = 16'hFFFF; c = 1'b1; end
         do_op(x, y, c, cyc, d, bo, ov, rdy, dn);
         r = ref_sub(x, y, c);
         checks++; if (cyc != 4) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected 4", k, cyc); end
         checks++; if (d !== r[15:0] || bo !== r[16]) begin errors++; $display("FAIL rnd%0d_result: got %h/%b expected %h/%b", k, d, bo, r[15:0], r[16]); end
`ifdef SERIAL_SUB_OVF_EN
         checks++; if (ov !== ref_ovf(x, y, c)) begin errors++; $display("FAIL rnd%0d_ovf: got %b expected %b", k, ov, ref_ovf(x, y, c)); end
`endif
      end
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      int cyc; logic [15:0] d; logic bo, ov, rdy, dn;
      do_op(16'h8000, 16'h0001, 1'b0, cyc, d, bo, ov, rdy, dn);
      checks++; if (d !== 16'h7FFF || ov !== 1'b1) begin errors++; $display("FAIL ovf_set: got %h/%b expected 7fff/1", d, ov); end
      do_op(16'h0003, 16'h0001, 1'b0, cyc, d, bo, ov, rdy, dn);
      checks++; if (d !== 16'h0002 || ov !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %h/%b expected 0002/0", d, ov); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_midrun();
      test_back_to_back();
      test_random();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
